// File: rtl/regbank_access_scheduler_if.sv
// Bundle of issue, execute, writeback and register-bank signals around the access scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline and bank.
interface regbank_access_scheduler_if #(
    parameter int LANES = 16,
    parameter int AW    = 6,
    parameter int DW    = 64
);
    logic                  iss_valid;
    logic                  iss_ready;
    logic [AW-1:0]         iss_rs1;
    logic [AW-1:0]         iss_rs2;
    logic [1:0]            iss_nsrc;
    logic [LANES-1:0]      iss_mask;

    logic                  opnd_valid;
    logic                  opnd_ready;
    logic [LANES*DW-1:0]   opnd_a;
    logic [LANES*DW-1:0]   opnd_b;
    logic [LANES-1:0]      opnd_mask;

    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [AW-1:0]         wb0_addr;
    logic [LANES-1:0]      wb0_mask;
    logic [LANES*DW-1:0]   wb0_data;
    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [AW-1:0]         wb1_addr;
    logic [LANES-1:0]      wb1_mask;
    logic [LANES*DW-1:0]   wb1_data;

    logic [LANES-1:0]      read_en_0;
    logic [LANES-1:0]      read_en_1;
    logic [AW-1:0]         raddr_0;
    logic [AW-1:0]         raddr_1;
    logic [LANES*DW-1:0]   rdata_0;
    logic [LANES*DW-1:0]   rdata_1;
    logic [LANES-1:0]      write_en;
    logic [AW-1:0]         waddr;
    logic [LANES*DW-1:0]   wdata;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_nsrc, iss_mask,
        output iss_ready,
        output opnd_valid, opnd_a, opnd_b, opnd_mask,
        input  opnd_ready,
        input  wb0_valid, wb0_addr, wb0_mask, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_addr, wb1_mask, wb1_data,
        output wb1_ready,
        output read_en_0, read_en_1, raddr_0, raddr_1,
        input  rdata_0, rdata_1,
        output write_en, waddr, wdata
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_nsrc, iss_mask,
        input  iss_ready,
        input  opnd_valid, opnd_a, opnd_b, opnd_mask,
        output opnd_ready,
        output wb0_valid, wb0_addr, wb0_mask, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_addr, wb1_mask, wb1_data,
        input  wb1_ready,
        input  read_en_0, read_en_1, raddr_0, raddr_1,
        output rdata_0, rdata_1,
        input  write_en, waddr, wdata
    );
endinterface

// File: rtl/regbank_access_scheduler.sv
// Operand-fetch sequencer for a 2R/1W lane-masked register bank with round-robin
// writeback arbitration and same-cycle write-to-read forwarding.
module regbank_access_scheduler #(
    parameter int LANES = 16,
    parameter int AW    = 6,
    parameter int DW    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    regbank_access_scheduler_if.slave bus
);
    localparam int W = LANES * DW;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic             iss_ready, accept;
    logic             prio_q;           // 0: wb0 preferred, 1: wb1 preferred
    logic             grant0, grant1;
    logic [LANES-1:0] wen, re0, re1;
    logic [AW-1:0]    waddr;
    logic [W-1:0]     wdata;
    logic [W-1:0]     opnd_a_q, opnd_b_q, opnd_a_d, opnd_b_d;
    logic [LANES-1:0] opnd_mask_q;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant0 = !rst && bus.wb0_valid && (!bus.wb1_valid || !prio_q);
        grant1 = !rst && bus.wb1_valid && !grant0;
        wen    = '0;
        waddr  = '0;
        wdata  = '0;
        if (grant0) begin
            wen   = bus.wb0_mask;
            waddr = bus.wb0_addr;
            wdata = bus.wb0_data;
        end else if (grant1) begin
            wen   = bus.wb1_mask;
            waddr = bus.wb1_addr;
            wdata = bus.wb1_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)         prio_q <= 1'b0;
        else if (grant0) prio_q <= 1'b1;
        else if (grant1) prio_q <= 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        iss_ready = 1'b0;
        case (state_q)
            IDLE: iss_ready = !rst;
            HOLD: iss_ready = !rst && bus.opnd_ready;
        endcase
        accept = bus.iss_valid && iss_ready;
        if (accept)                                state_d = HOLD;
        else if (state_q == HOLD && bus.opnd_ready) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // nsrc of 3 behaves as 2: bit 1 alone selects source B.
    assign re0 = (accept && bus.iss_nsrc != 2'd0) ? bus.iss_mask : '0;
    assign re1 = (accept && bus.iss_nsrc[1])      ? bus.iss_mask : '0;

    always_comb begin
        opnd_a_d = '0;
        opnd_b_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (re0[i])
                opnd_a_d[i*DW +: DW] = (wen[i] && waddr == bus.iss_rs1) ? wdata[i*DW +: DW]
                                                                         : bus.rdata_0[i*DW +: DW];
            if (re1[i])
                opnd_b_d[i*DW +: DW] = (wen[i] && waddr == bus.iss_rs2) ? wdata[i*DW +: DW]
                                                                         : bus.rdata_1[i*DW +: DW];
        end
    end

    // NOTE: operand registers are cleared on reset so a dropped bundle never leaks stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_a_q    <= '0;
            opnd_b_q    <= '0;
            opnd_mask_q <= '0;
        end else if (accept) begin
            opnd_a_q    <= opnd_a_d;
            opnd_b_q    <= opnd_b_d;
            opnd_mask_q <= bus.iss_mask;
        end
    end

    assign bus.iss_ready  = iss_ready;
    assign bus.opnd_valid = (state_q == HOLD);
    assign bus.opnd_a     = opnd_a_q;
    assign bus.opnd_b     = opnd_b_q;
    assign bus.opnd_mask  = opnd_mask_q;
    assign bus.wb0_ready  = grant0;
    assign bus.wb1_ready  = grant1;
    assign bus.read_en_0  = re0;
    assign bus.read_en_1  = re1;
    assign bus.raddr_0    = bus.iss_rs1;
    assign bus.raddr_1    = bus.iss_rs2;
    assign bus.write_en   = wen;
    assign bus.waddr      = waddr;
    assign bus.wdata      = wdata;
endmodule

// File: tb/tb_regbank_access_scheduler.sv
// Directed bench for regbank_access_scheduler: a bank model driven by the DUT, plus a
// register-file/ordering model checked against the DUT on every negedge.
module tb_regbank_access_scheduler;
    localparam int LANES = 16;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int W     = LANES * DW;
    localparam int NREG  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic started = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regbank_access_scheduler_if #(.LANES(LANES), .AW(AW), .DW(DW)) bi ();

    regbank_access_scheduler #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    function automatic logic [W-1:0] ramp(input logic [DW-1:0] base);
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = base + DW'(i);
        return v;
    endfunction

    function automatic logic [W-1:0] fill(input logic [DW-1:0] val);
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = val;
        return v;
    endfunction

    function automatic logic [DW-1:0] lane(input logic [W-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Bank environment: written by the DUT's port, read combinationally; disabled lanes return junk.
    logic [W-1:0] bank [NREG];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bi.rdata_0[i*DW +: DW] = bi.read_en_0[i] ? bank[bi.raddr_0][i*DW +: DW] : 64'hEEEE_EEEE_EEEE_EEEE;
            bi.rdata_1[i*DW +: DW] = bi.read_en_1[i] ? bank[bi.raddr_1][i*DW +: DW] : 64'hEEEE_EEEE_EEEE_EEEE;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (bi.write_en[i]) bank[bi.waddr][i*DW +: DW] <= bi.wdata[i*DW +: DW];
    end

    // Reference model: its own register file, pending bundle and last-granted source.
    logic [W-1:0]     m_rf [NREG];
    logic             m_valid;
    logic [W-1:0]     m_a, m_b;
    logic [LANES-1:0] m_mask;
    logic             m_wb0_next;   // wb0 wins a tie when set

    logic             e_iss_ready, e_acc, e_g0, e_g1;
    logic [LANES-1:0] e_wen, e_re0, e_re1;
    logic [AW-1:0]    e_waddr;
    logic [W-1:0]     e_wdata;

    always_comb begin
        e_iss_ready = !rst && (!m_valid || bi.opnd_ready);
        e_acc       = bi.iss_valid && e_iss_ready;
        e_g0        = !rst && bi.wb0_valid && (!bi.wb1_valid || m_wb0_next);
        e_g1        = !rst && bi.wb1_valid && !e_g0;
        e_wen       = e_g0 ? bi.wb0_mask : (e_g1 ? bi.wb1_mask : '0);
        e_waddr     = e_g0 ? bi.wb0_addr : (e_g1 ? bi.wb1_addr : '0);
        e_wdata     = e_g0 ? bi.wb0_data : (e_g1 ? bi.wb1_data : '0);
        e_re0       = (e_acc && bi.iss_nsrc >= 2'd1) ? bi.iss_mask : '0;
        e_re1       = (e_acc && bi.iss_nsrc >= 2'd2) ? bi.iss_mask : '0;
    end

    always @(posedge clk) begin
        logic             acc, g0, g1;
        logic [LANES-1:0] wen, re0, re1;
        logic [AW-1:0]    wa, rs1, rs2;
        logic [W-1:0]     wd;
        acc = e_acc; g0 = e_g0; g1 = e_g1; wen = e_wen; wa = e_waddr; wd = e_wdata;
        re0 = e_re0; re1 = e_re1; rs1 = bi.iss_rs1; rs2 = bi.iss_rs2;
        if (rst) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_mask = '0; m_wb0_next = 1'b1;
        end else begin
            if (acc) begin
                for (int i = 0; i < LANES; i++) begin
                    m_a[i*DW +: DW] = !re0[i] ? '0 : ((wen[i] && wa == rs1) ? lane(wd, i) : lane(m_rf[rs1], i));
                    m_b[i*DW +: DW] = !re1[i] ? '0 : ((wen[i] && wa == rs2) ? lane(wd, i) : lane(m_rf[rs2], i));
                end
                m_mask  = bi.iss_mask;
                m_valid = 1'b1;
            end else if (bi.opnd_ready) begin
                m_valid = 1'b0;
            end
            if (g0 || g1) begin
                for (int i = 0; i < LANES; i++)
                    if (wen[i]) m_rf[wa][i*DW +: DW] = lane(wd, i);
                m_wb0_next = g1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("iss_ready",  64'(bi.iss_ready),  64'(e_iss_ready));
            check("opnd_valid", 64'(bi.opnd_valid), 64'(m_valid));
            check("wb0_ready",  64'(bi.wb0_ready),  64'(e_g0));
            check("wb1_ready",  64'(bi.wb1_ready),  64'(e_g1));
            check("write_en",   64'(bi.write_en),   64'(e_wen));
            check("waddr",      64'(bi.waddr),      64'(e_waddr));
            check("read_en_0",  64'(bi.read_en_0),  64'(e_re0));
            check("read_en_1",  64'(bi.read_en_1),  64'(e_re1));
            check("raddr_0",    64'(bi.raddr_0),    64'(bi.iss_rs1));
            check("raddr_1",    64'(bi.raddr_1),    64'(bi.iss_rs2));
            for (int i = 0; i < LANES; i++)
                check($sformatf("wdata[%0d]", i), lane(bi.wdata, i), lane(e_wdata, i));
            if (m_valid) begin
                check("opnd_mask", 64'(bi.opnd_mask), 64'(m_mask));
                for (int i = 0; i < LANES; i++) begin
                    check($sformatf("opnd_a[%0d]", i), lane(bi.opnd_a, i), lane(m_a, i));
                    check($sformatf("opnd_b[%0d]", i), lane(bi.opnd_b, i), lane(m_b, i));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [1:0] n, input logic [LANES-1:0] m);
        bi.iss_valid = v; bi.iss_rs1 = r1; bi.iss_rs2 = r2; bi.iss_nsrc = n; bi.iss_mask = m;
    endtask

    task automatic wb0(input logic v, input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [W-1:0] d);
        bi.wb0_valid = v; bi.wb0_addr = a; bi.wb0_mask = m; bi.wb0_data = d;
    endtask

    task automatic wb1(input logic v, input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [W-1:0] d);
        bi.wb1_valid = v; bi.wb1_addr = a; bi.wb1_mask = m; bi.wb1_data = d;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            bank[r] = fill(64'hBAD0 + 64'(r));
            m_rf[r] = fill(64'hBAD0 + 64'(r));
        end
        m_valid = 1'b0; m_a = '0; m_b = '0; m_mask = '0; m_wb0_next = 1'b1;
        rst = 1'b1;
        bi.opnd_ready = 1'b1;
        fetch(1'b1, 6'd0, 6'd0, 2'd2, 16'hFFFF);
        wb0(1'b1, 6'd7, 16'hFFFF, fill(64'h1));
        wb1(1'b0, 6'd0, 16'h0, '0);

        // Reset holds every handshake and bank enable low.
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("rst_iss_ready",  64'(bi.iss_ready),  64'd0);
        check("rst_wb0_ready",  64'(bi.wb0_ready),  64'd0);
        check("rst_write_en",   64'(bi.write_en),   64'd0);
        check("rst_read_en_0",  64'(bi.read_en_0),  64'd0);
        check("rst_opnd_valid", 64'(bi.opnd_valid), 64'd0);

        // Single writeback: r5 <- 'h100+i on all lanes.
        cyc();
        rst = 1'b0;
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        wb0(1'b1, 6'd5, 16'hFFFF, ramp(64'h100));
        @(negedge clk);
        check("wr_write_en", 64'(bi.write_en), 64'hFFFF);
        check("wr_waddr",    64'(bi.waddr),    64'd5);
        check("wr_wb0_ready", 64'(bi.wb0_ready), 64'd1);

        // One-source fetch of r5 on the low eight lanes.
        cyc();
        wb0(1'b0, 6'd0, 16'h0, '0);
        fetch(1'b1, 6'd5, 6'd0, 2'd1, 16'h00FF);
        @(negedge clk);
        check("f1_read_en_0", 64'(bi.read_en_0), 64'h00FF);
        check("f1_read_en_1", 64'(bi.read_en_1), 64'h0);
        cyc();
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        @(negedge clk);
        check("f1_opnd_valid", 64'(bi.opnd_valid), 64'd1);
        check("f1_a_lane0", lane(bi.opnd_a, 0), 64'h100);
        check("f1_a_lane7", lane(bi.opnd_a, 7), 64'h107);
        check("f1_a_lane8", lane(bi.opnd_a, 8), 64'h0);
        check("f1_b_lane0", lane(bi.opnd_b, 0), 64'h0);
        check("f1_mask", 64'(bi.opnd_mask), 64'h00FF);

        // Forwarding: wb1 writes r9 in the same cycle both sources read r9.
        cyc();
        wb1(1'b1, 6'd9, 16'hFFFF, fill(64'hDEAD));
        fetch(1'b1, 6'd9, 6'd9, 2'd2, 16'hFFFF);
        @(negedge clk);
        check("byp_wb1_ready", 64'(bi.wb1_ready), 64'd1);
        cyc();
        wb1(1'b0, 6'd0, 16'h0, '0);
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        @(negedge clk);
        check("byp_a_lane0",  lane(bi.opnd_a, 0),  64'hDEAD);
        check("byp_a_lane15", lane(bi.opnd_a, 15), 64'hDEAD);
        check("byp_b_lane3",  lane(bi.opnd_b, 3),  64'hDEAD);

        // Contention: both sources valid for four cycles must alternate starting at wb0.
        for (int k = 0; k < 4; k++) begin
            cyc();
            wb0(1'b1, 6'd1, 16'hFFFF, ramp(64'hA000));
            wb1(1'b1, 6'd2, 16'hF0F0, ramp(64'hB000));
            @(negedge clk);
            check($sformatf("cont_g0_%0d", k), 64'(bi.wb0_ready), 64'((k % 2) == 0));
            check($sformatf("cont_g1_%0d", k), 64'(bi.wb1_ready), 64'((k % 2) == 1));
        end
        cyc();
        wb0(1'b0, 6'd0, 16'h0, '0);
        wb1(1'b0, 6'd0, 16'h0, '0);

        // nsrc = 3 acts as 2; nsrc = 0 reads nothing.
        fetch(1'b1, 6'd1, 6'd2, 2'd3, 16'h0F0F);
        cyc();
        fetch(1'b1, 6'd1, 6'd2, 2'd0, 16'hFFFF);
        @(negedge clk);
        check("n3_a_lane0", lane(bi.opnd_a, 0), 64'hA000);
        check("n3_b_lane0", lane(bi.opnd_b, 0), 64'hBAD2);
        check("n3_b_lane4", lane(bi.opnd_b, 4), 64'h0);
        cyc();
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        @(negedge clk);
        check("n0_a_lane0", lane(bi.opnd_a, 0), 64'h0);
        check("n0_mask", 64'(bi.opnd_mask), 64'hFFFF);

        // Backpressure: bundle from r5/r9 must hold while execute stalls.
        cyc();
        bi.opnd_ready = 1'b0;
        fetch(1'b1, 6'd5, 6'd9, 2'd2, 16'hFFFF);
        @(negedge clk);
        check("bp_accept", 64'(bi.iss_ready), 64'd1);
        cyc();
        fetch(1'b1, 6'd1, 6'd2, 2'd2, 16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_stall_ready_%0d", k), 64'(bi.iss_ready), 64'd0);
            check($sformatf("bp_stall_a_%0d", k), lane(bi.opnd_a, 0), 64'h100);
            check($sformatf("bp_stall_b_%0d", k), lane(bi.opnd_b, 0), 64'hDEAD);
            if (k < 2) cyc();
        end
        cyc();
        bi.opnd_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready0", 64'(bi.iss_ready), 64'd1);
        cyc();
        fetch(1'b1, 6'd2, 6'd1, 2'd2, 16'hFFFF);
        @(negedge clk);
        check("bp_rel_ready1", 64'(bi.iss_ready), 64'd1);
        check("bp_rel_a_lane0", lane(bi.opnd_a, 0), 64'hA000);
        cyc();
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        @(negedge clk);
        check("bp_b2b_a_lane4", lane(bi.opnd_a, 4), 64'hB004);
        check("bp_b2b_a_lane0", lane(bi.opnd_a, 0), 64'hBAD2);

        // Reset while holding a bundle, with the arbiter pointer moved to wb1.
        cyc();
        bi.opnd_ready = 1'b0;
        wb0(1'b1, 6'd3, 16'h0001, fill(64'h3333));
        fetch(1'b1, 6'd1, 6'd0, 2'd1, 16'hFFFF);
        @(negedge clk);
        check("rh_pre_wb0", 64'(bi.wb0_ready), 64'd1);
        cyc();
        rst = 1'b1;
        wb0(1'b1, 6'd3, 16'h0002, fill(64'h4444));
        wb1(1'b1, 6'd4, 16'h0004, fill(64'h5555));
        @(negedge clk);
        check("rh_iss_ready", 64'(bi.iss_ready), 64'd0);
        check("rh_wb0_ready", 64'(bi.wb0_ready), 64'd0);
        check("rh_wb1_ready", 64'(bi.wb1_ready), 64'd0);
        check("rh_write_en",  64'(bi.write_en),  64'd0);
        check("rh_read_en_0", 64'(bi.read_en_0), 64'd0);
        cyc();
        rst = 1'b0;
        fetch(1'b0, 6'd0, 6'd0, 2'd0, 16'h0);
        @(negedge clk);
        check("rh_post_valid", 64'(bi.opnd_valid), 64'd0);
        check("rh_post_ready", 64'(bi.iss_ready),  64'd1);
        check("rh_post_wb0",   64'(bi.wb0_ready),  64'd1);
        check("rh_post_wb1",   64'(bi.wb1_ready),  64'd0);
        check("rh_post_a",     lane(bi.opnd_a, 0), 64'h0);

        cyc();
        wb0(1'b0, 6'd0, 16'h0, '0);
        wb1(1'b0, 6'd0, 16'h0, '0);
        bi.opnd_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
